// File: rtl/cu_mc.sv
// cu_mc: multi-cycle fetch/execute controller for the mycpu datapath; outputs are combinational from state, instruction, flags and ready.
// Optional interrupt servicing is built when CU_IRQ_EN is defined.
module cu_mc #(
  parameter int RA_W     = 3,
  parameter int OPC_W    = 7,
  parameter int WAIT_MAX = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [OPC_W+3*RA_W-1:0]   ins_in,
  input  logic                      z_in,
  input  logic                      n_in,
  input  logic                      mem_rdy_in,
  input  logic                      resume_in,
  input  logic                      irq_in,
  output logic                      il_out,
  output logic [1:0]                ps_out,
  output logic                      rw_out,
  output logic [3*(RA_W+1)-1:0]     rs_out,
  output logic                      mm_out,
  output logic [1:0]                md_out,
  output logic                      mb_out,
  output logic [3:0]                fs_out,
  output logic                      wen_out,
  output logic                      iom_out,
  output logic                      halt_out,
  output logic                      err_out,
  output logic                      irq_ack_out
);

  localparam int IW = OPC_W + 3*RA_W;
  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [2:0] S_RST = 3'd0;
  localparam logic [2:0] S_INF = 3'd1;
  localparam logic [2:0] S_EX0 = 3'd2;
  localparam logic [2:0] S_MWT = 3'd3;
  localparam logic [2:0] S_XXL = 3'd4;
  localparam logic [2:0] S_HLT = 3'd5;
  localparam logic [2:0] S_IRQ = 3'd6;

  // Opcode encodings shared with the mycpu datapath (low nibble doubles as ALU function).
  localparam logic [OPC_W-1:0] OP_LD  = OPC_W'('h10);
  localparam logic [OPC_W-1:0] OP_ST  = OPC_W'('h20);
  localparam logic [OPC_W-1:0] OP_IOR = OPC_W'('h11);
  localparam logic [OPC_W-1:0] OP_IOW = OPC_W'('h21);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'('h4C);
  localparam logic [OPC_W-1:0] OP_ADI = OPC_W'('h42);
  localparam logic [OPC_W-1:0] OP_BRZ = OPC_W'('h60);
  localparam logic [OPC_W-1:0] OP_BRN = OPC_W'('h61);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'('h44);
  localparam logic [OPC_W-1:0] OP_HAL = OPC_W'('h7F);
  localparam logic [OPC_W-1:0] OP_XXL = OPC_W'('h3E);

  logic [2:0]               r_st;
  logic [CW-1:0]            r_cnt;
  logic                     r_err;

  logic [2:0]               w_ns;
  logic                     w_cnt_clr, w_cnt_inc, w_err_set, w_err_clr;
  logic [OPC_W-1:0]         w_opc;
  logic [RA_W-1:0]          w_rd, w_ra, w_rb;
  logic                     w_mem, w_rw_dec;
  logic [1:0]               w_ps_dec, w_md_dec;
  logic [3:0]               w_fs_dec;
  logic [3*(RA_W+1)-1:0]    w_rs_dec;
  logic                     w_timeout;

  assign w_opc = ins_in[IW-1 -: OPC_W];
  assign w_rd  = ins_in[3*RA_W-1 -: RA_W];
  assign w_ra  = ins_in[2*RA_W-1 -: RA_W];
  assign w_rb  = ins_in[RA_W-1:0];

  assign w_rs_dec = {1'b0, w_rd, 1'b0, w_ra, 1'b0, w_rb};
  assign w_mem    = (w_opc == OP_LD) || (w_opc == OP_ST) || (w_opc == OP_IOR) || (w_opc == OP_IOW);
  assign w_rw_dec = !((w_opc == OP_ST)  || (w_opc == OP_BRZ) || (w_opc == OP_BRN) ||
                      (w_opc == OP_JMP) || (w_opc == OP_IOW) || (w_opc == OP_HAL) ||
                      (w_opc == OP_XXL));
  assign w_fs_dec = (w_opc == OP_BRN) ? 4'b0000 :
                    (w_opc == OP_XXL) ? 4'b1110 : w_opc[3:0];
  assign w_md_dec = (w_opc == OP_LD)  ? 2'b01 :
                    (w_opc == OP_IOR) ? 2'b10 : 2'b00;
  assign w_ps_dec = (w_opc == OP_BRZ) ? (z_in ? 2'b10 : 2'b01) :
                    (w_opc == OP_BRN) ? (n_in ? 2'b10 : 2'b01) :
                    (w_opc == OP_JMP) ? 2'b11 :
                    ((w_opc == OP_HAL) || (w_opc == OP_XXL)) ? 2'b00 : 2'b01;
  // Timeout fires on the WAIT_MAX-th MWT cycle; the counter is still one short then.
  assign w_timeout = (r_cnt == CW'(WAIT_MAX - 1));

`ifndef CU_IRQ_EN
  logic w_unused_irq;
  assign w_unused_irq = irq_in;
`endif

  always_comb begin
    il_out      = 1'b0;
    ps_out      = 2'b00;
    rw_out      = 1'b0;
    rs_out      = '0;
    mm_out      = 1'b0;
    md_out      = 2'b00;
    mb_out      = 1'b0;
    fs_out      = 4'b0000;
    wen_out     = 1'b1;
    iom_out     = 1'b0;
    halt_out    = 1'b0;
    irq_ack_out = 1'b0;
    w_ns        = r_st;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;

    case (r_st)
      S_RST: w_ns = S_INF;

      S_INF: begin
        w_cnt_clr = 1'b1;
`ifdef CU_IRQ_EN
        if (irq_in) begin
          w_ns = S_IRQ;
        end else begin
          il_out = 1'b1;
          w_ns   = S_EX0;
        end
`else
        il_out = 1'b1;
        w_ns   = S_EX0;
`endif
      end

      S_EX0, S_MWT: begin
        rs_out  = w_rs_dec;
        fs_out  = w_fs_dec;
        mb_out  = (w_opc == OP_LDI) || (w_opc == OP_ADI);
        md_out  = w_md_dec;
        iom_out = (w_opc == OP_IOR) || (w_opc == OP_IOW);
        wen_out = !((w_opc == OP_ST) || (w_opc == OP_IOW));
        if (r_st == S_MWT) begin
          w_cnt_inc = 1'b1;
          if (mem_rdy_in) begin
            rw_out = w_rw_dec;
            ps_out = 2'b01;
            w_ns   = S_INF;
          end else if (w_timeout) begin
            w_err_set = 1'b1;
            w_ns      = S_HLT;
          end
        end else if (w_mem) begin
          if (mem_rdy_in) begin
            rw_out = w_rw_dec;
            ps_out = 2'b01;
            w_ns   = S_INF;
          end else begin
            w_ns = S_MWT;
          end
        end else begin
          rw_out = w_rw_dec;
          ps_out = w_ps_dec;
          if (w_opc == OP_HAL)
            w_ns = S_HLT;
          else if (w_opc == OP_XXL)
            w_ns = z_in ? S_INF : S_XXL;
          else
            w_ns = S_INF;
        end
      end

      S_XXL: begin
        mm_out = 1'b1;
        fs_out = 4'b1110;
        if (z_in) begin
          ps_out = 2'b01;
          w_ns   = S_INF;
        end
      end

      S_HLT: begin
        halt_out = 1'b1;
        if (resume_in) begin
          ps_out    = 2'b01;
          w_err_clr = 1'b1;
          w_ns      = S_INF;
        end
      end

      S_IRQ: begin
`ifdef CU_IRQ_EN
        irq_ack_out = 1'b1;
`endif
        w_ns = S_INF;
      end

      default: w_ns = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st  <= S_RST;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_st <= w_ns;
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (w_cnt_inc)
        r_cnt <= r_cnt + 1'b1;
      if (w_err_set)
        r_err <= 1'b1;
      else if (w_err_clr)
        r_err <= 1'b0;
    end
  end

  assign err_out = r_err;

endmodule

// File: tb/tb_cu_mc.sv
// Directed bench for cu_mc: hand-computed control outputs per instruction and state.
module tb_cu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ins_in;
  logic        z_in, n_in, mem_rdy_in, resume_in, irq_in;
  logic        il_out, rw_out, mm_out, mb_out, wen_out, iom_out, halt_out, err_out, irq_ack_out;
  logic [1:0]  ps_out, md_out;
  logic [11:0] rs_out;
  logic [3:0]  fs_out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] LD  = 7'h10, ST  = 7'h20, IOR = 7'h11, IOW = 7'h21;
  localparam logic [6:0] ADI = 7'h42, BRZ = 7'h60, BRN = 7'h61, JMP = 7'h44;
  localparam logic [6:0] HAL = 7'h7F, XXL = 7'h3E, UNK = 7'h0A;

  cu_mc #(.RA_W(3), .OPC_W(7), .WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .ins_in(ins_in), .z_in(z_in), .n_in(n_in),
    .mem_rdy_in(mem_rdy_in), .resume_in(resume_in), .irq_in(irq_in),
    .il_out(il_out), .ps_out(ps_out), .rw_out(rw_out), .rs_out(rs_out),
    .mm_out(mm_out), .md_out(md_out), .mb_out(mb_out), .fs_out(fs_out),
    .wen_out(wen_out), .iom_out(iom_out), .halt_out(halt_out), .err_out(err_out),
    .irq_ack_out(irq_ack_out)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] d,
                                     input logic [2:0] a, input logic [2:0] b);
    return {op, d, a, b};
  endfunction

  // From INF: present instruction and advance into EX0.
  task automatic to_ex0(input logic [15:0] v);
    ins_in = v;
    tick();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ins_in = '0; z_in = 0; n_in = 0;
    mem_rdy_in = 0; resume_in = 0; irq_in = 0;
    tick(); tick();
    expect_eq("rst_il",   il_out, 0);
    expect_eq("rst_ps",   ps_out, 0);
    expect_eq("rst_rs",   rs_out, 0);
    expect_eq("rst_wen",  wen_out, 1);
    expect_eq("rst_err",  err_out, 0);
    expect_eq("rst_misc", {rw_out, mm_out, md_out, mb_out, fs_out, iom_out, halt_out, irq_ack_out}, 0);

    rst_n = 1'b1;
    tick(); #1;
    expect_eq("inf_il", il_out, 1);

    // LD with three stalled MWT cycles
    to_ex0(mk(LD, 3'd2, 3'd5, 3'd0));
    expect_eq("ld_ex0_rw", rw_out, 0);
    expect_eq("ld_ex0_ps", ps_out, 0);
    expect_eq("ld_ex0_md", md_out, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      expect_eq("ld_mwt_rw", rw_out, 0);
      expect_eq("ld_mwt_ps", ps_out, 0);
    end
    tick(); mem_rdy_in = 1; #1;
    expect_eq("ld_rdy_rw", rw_out, 1);
    expect_eq("ld_rdy_md", md_out, 2'b01);
    expect_eq("ld_rdy_rs", rs_out, 12'h250);
    expect_eq("ld_rdy_ps", ps_out, 2'b01);
    tick(); mem_rdy_in = 0; #1;
    expect_eq("ld_next_il", il_out, 1);

    // Reset asserted in the middle of a stalled store
    to_ex0(mk(ST, 3'd0, 3'd1, 3'd3));
    expect_eq("st_ex0_wen", wen_out, 0);
    expect_eq("st_ex0_rs",  rs_out, 12'h013);
    tick(); tick();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      expect_eq("mrst_wen", wen_out, 1);
      expect_eq("mrst_il",  il_out, 0);
      expect_eq("mrst_err", err_out, 0);
      expect_eq("mrst_rw_ps", {rw_out, ps_out, halt_out}, 0);
    end
    rst_n = 1'b1;
    tick(); #1;
    expect_eq("mrst_inf_il", il_out, 1);

    // Store that never completes: EX0 + 15 MWT with wen low, then HLT with err
    to_ex0(mk(ST, 3'd0, 3'd1, 3'd3));
    for (int i = 0; i < 16; i++) begin
      expect_eq("to_wen",  wen_out, 0);
      expect_eq("to_halt", halt_out, 0);
      tick(); #1;
    end
    expect_eq("to_hlt_halt", halt_out, 1);
    expect_eq("to_hlt_err",  err_out, 1);
    expect_eq("to_hlt_wen",  wen_out, 1);
    tick(); #1;
    expect_eq("to_hold_halt", halt_out, 1);
    resume_in = 1; #1;
    expect_eq("to_res_ps", ps_out, 2'b01);
    tick(); resume_in = 0; #1;
    expect_eq("to_res_err", err_out, 0);
    expect_eq("to_res_il",  il_out, 1);

    // Branches
    n_in = 1;
    to_ex0(mk(BRN, 3'd1, 3'd2, 3'd3));
    expect_eq("brn_ps", ps_out, 2'b10);
    expect_eq("brn_fs", fs_out, 0);
    expect_eq("brn_rw", rw_out, 0);
    tick(); n_in = 0;
    to_ex0(mk(BRZ, 3'd0, 3'd0, 3'd0));
    expect_eq("brz0_ps", ps_out, 2'b01);
    tick(); z_in = 1;
    to_ex0(mk(BRZ, 3'd0, 3'd0, 3'd0));
    expect_eq("brz1_ps", ps_out, 2'b10);
    tick(); z_in = 0;
    to_ex0(mk(JMP, 3'd0, 3'd0, 3'd0));
    expect_eq("jmp_ps", ps_out, 2'b11);
    expect_eq("jmp_rw", rw_out, 0);
    tick();

    // ALU-class and IO instructions
    to_ex0(mk(ADI, 3'd1, 3'd2, 3'd3));
    expect_eq("adi_mb", mb_out, 1);
    expect_eq("adi_rw", rw_out, 1);
    expect_eq("adi_fs", fs_out, 4'h2);
    expect_eq("adi_rs", rs_out, 12'h123);
    tick();
    mem_rdy_in = 1;
    to_ex0(mk(IOR, 3'd3, 3'd0, 3'd0));
    expect_eq("ior_md",  md_out, 2'b10);
    expect_eq("ior_iom", iom_out, 1);
    expect_eq("ior_rw",  rw_out, 1);
    expect_eq("ior_ps",  ps_out, 2'b01);
    tick();
    to_ex0(mk(IOW, 3'd0, 3'd4, 3'd6));
    expect_eq("iow_wen", wen_out, 0);
    expect_eq("iow_iom", iom_out, 1);
    expect_eq("iow_rw",  rw_out, 0);
    tick(); mem_rdy_in = 0;
    to_ex0(mk(UNK, 3'd7, 3'd0, 3'd0));
    expect_eq("unk_rw", rw_out, 1);
    expect_eq("unk_ps", ps_out, 2'b01);
    expect_eq("unk_fs", fs_out, 4'hA);
    tick();

    // XXL loop: waits in its own state until z rises
    to_ex0(mk(XXL, 3'd1, 3'd1, 3'd1));
    expect_eq("xxl_ex0_fs", fs_out, 4'hE);
    expect_eq("xxl_ex0_ps", ps_out, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      expect_eq("xxl_mm", mm_out, 1);
      expect_eq("xxl_rs", rs_out, 0);
      expect_eq("xxl_fs", fs_out, 4'hE);
      expect_eq("xxl_ps", ps_out, 2'b00);
    end
    z_in = 1; #1;
    expect_eq("xxl_exit_ps", ps_out, 2'b01);
    tick(); z_in = 0; #1;
    expect_eq("xxl_inf_il", il_out, 1);

    // HAL then resume; resume outside HLT has no effect
    resume_in = 1; #1;
    expect_eq("res_inf_il", il_out, 1);
    resume_in = 0;
    to_ex0(mk(HAL, 3'd0, 3'd0, 3'd0));
    expect_eq("hal_ps", ps_out, 2'b00);
    tick(); #1;
    expect_eq("hal_halt", halt_out, 1);
    expect_eq("hal_err",  err_out, 0);
    resume_in = 1; #1;
    expect_eq("hal_res_ps", ps_out, 2'b01);
    tick(); resume_in = 0; #1;
    expect_eq("hal_inf_il", il_out, 1);

    // Interrupt request sampled in INF
    irq_in = 1; #1;
`ifdef CU_IRQ_EN
    expect_eq("irq_inf_il", il_out, 0);
    tick(); irq_in = 0; #1;
    expect_eq("irq_ack", irq_ack_out, 1);
    tick(); #1;
    expect_eq("irq_ack_off", irq_ack_out, 0);
    expect_eq("irq_inf_il2", il_out, 1);
`else
    expect_eq("noirq_il",  il_out, 1);
    expect_eq("noirq_ack", irq_ack_out, 0);
    tick(); irq_in = 0; #1;
    expect_eq("noirq_ex0_ack", irq_ack_out, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
